step_sequencer: RTL and testbench
=================================

// Module: step_sequencer
// PURPOSE
//   Pattern scheduler for the drum machine. Holds one STEPS-bit on/off pattern per voice and a
//   step counter advanced by the bpm strobe. Emits one-cycle trigger pulses to the four sample
//   players (kick, snare, hat, clap) and exports step/pattern state to the VGA and HEX logic.
//   Pattern edits arrive from the switch/key front end through a write strobe.
// PARAMETERS
//   STEPS   8  steps per bar; power of two, 2..16
//   VOICES  4  number of voices/patterns
//   STEP_W  3  log2(STEPS)
// PORTS
//   clk           in   1               system clock (CLOCK_50 domain)
//   reset         in   1               asynchronous, active-low; clears all state
//   tick          in   1               one-cycle step strobe from bpm; never two consecutive cycles
//   play          in   1               level; 1 = run, 0 = stop
//   mute          in   VOICES          per-voice trigger mask, sampled on the firing cycle
//   edit_we       in   1               pattern write strobe, one cycle
//   edit_voice    in   2               voice index for the write (0 kick, 1 snare, 2 hat, 3 clap)
//   edit_pattern  in   STEPS           new pattern; bit i = step i
//   trig          out  VOICES          one-cycle trigger pulse per voice
//   step          out  STEP_W          step currently sounding
//   bar_start     out  1               one-cycle pulse with the step-0 triggers
//   running       out  1               1 in ARM or RUN
//   patterns      out  VOICES*STEPS    all patterns flat; voice v at [v*STEPS +: STEPS]
// BEHAVIOUR
//   Reset values: trig=0, step=0, bar_start=0, running=0, patterns=0, state=IDLE.
//   FSM states: IDLE, ARM, RUN.
//     IDLE: tick is ignored; outputs hold at reset values except patterns.
//       play=1 -> ARM.
//     ARM: lasts exactly one cycle.
//       Next cycle: step=0, trig[v]=pat[v][0] & ~mute[v], bar_start=1.
//       A tick in the ARM cycle is dropped.
//       play=0 in the ARM cycle -> IDLE with no triggers.
//       Otherwise -> RUN.
//     RUN:
//       tick=1 -> next cycle: step <= (step+1) mod STEPS; trig[v] = pat[v][new step] & ~mute[v].
//       bar_start=1 when the new step = 0; wrap STEPS-1 -> 0 is seamless.
//       play=0 -> next cycle IDLE, step=0, trig=0. A same-cycle tick is discarded.
//   Latency: tick to trig/step is 1 cycle. trig is registered and high for exactly 1 cycle.
//   Edits:
//     Accepted in every state; pat[edit_voice] <= edit_pattern next cycle.
//     edit_we in the same cycle as tick: trigger uses the OLD pattern; new pattern applies from
//       the following step.
//     edit_we with edit_voice >= VOICES is ignored.
//   patterns output reflects the registered pattern store (1-cycle after edit_we).
//   Reset asserted mid-run: trig drops immediately (async); patterns are lost.
// STRUCTURE
//   Shared package drum_pkg:
//     STEPS, VOICES, STEP_W
//     voice index constants V_KICK=0, V_SNARE=1, V_HAT=2, V_CLAP=3
//     seq_state_t {IDLE, ARM, RUN}
//   One sub-module: pattern_regs.
//     VOICES x STEPS register file, one write port, flat read-all output.
//     Same clk/reset; cleared on reset.
//   FSM, step counter and trigger register stay in step_sequencer.
// TESTING
//   1 Reset, load kick=8'b0001_0001, play=1
//       -> cycle after ARM: trig=4'b0001, step=0, bar_start=1.
//   2 Continue with ticks
//       -> kick pulses at steps 0 and 4 only; 8th tick gives step 7->0 with bar_start=1.
//   3 edit_we with snare=8'hFF on the same cycle as the tick into step 2
//       -> no snare on step 2; snare fires on step 3.
//   4 play=0 on the same cycle as a tick while at step 5
//       -> no trig, step=0, running=0 the next cycle. Replay restarts at step 0.
//   5 mute=4'b0010 with all patterns 8'hFF
//       -> trig=4'b1101 on every step. Ticks in IDLE or ARM produce no trig.
//   6 Pulse reset low mid-RUN at step 6
//       -> all outputs 0 and patterns 0 immediately. No trig until play is re-asserted.

Source files
------------

// File: rtl/drum_pkg.sv
// Shared definitions for the drum machine step sequencer.
//   STEPS  / VOICES / STEP_W : default geometry (8 steps, 4 voices, 3-bit step index)
//   V_*                      : voice index constants used by the edit front end
//   seq_state_t              : sequencer FSM states
package drum_pkg;
  localparam int STEPS  = 8;
  localparam int VOICES = 4;
  localparam int STEP_W = 3;

  localparam int V_KICK  = 0;
  localparam int V_SNARE = 1;
  localparam int V_HAT   = 2;
  localparam int V_CLAP  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } seq_state_t;
endpackage

// File: rtl/pattern_regs.sv
// Pattern register file: VOICES patterns of STEPS bits each.
//   clk, reset (async, active-low) : clock and clear
//   we, wvoice, wdata              : single write port; out-of-range voice is ignored
//   pat_flat                       : all patterns, voice v at [v*STEPS +: STEPS]
module pattern_regs
  import drum_pkg::*;
#(
  parameter int P_STEPS  = STEPS,
  parameter int P_VOICES = VOICES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          we,
  input  logic [1:0]                    wvoice,
  input  logic [P_STEPS-1:0]            wdata,
  output logic [P_VOICES*P_STEPS-1:0]   pat_flat
);

  for (genvar gi = 0; gi < P_VOICES; gi++) begin : g_voice
    logic [P_STEPS-1:0] pat_d;
    logic [P_STEPS-1:0] pat_q;

    // A voice index with no matching slot simply matches nothing.
    always_comb begin
      pat_d = pat_q;
      if (we && (int'(wvoice) == gi)) begin
        pat_d = wdata;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pat_q <= '0;
      end else begin
        pat_q <= pat_d;
      end
    end

    assign pat_flat[gi*P_STEPS +: P_STEPS] = pat_q;
  end

endmodule

// File: rtl/step_sequencer.sv
// Drum machine step sequencer.
//   clk, reset (async, active-low)
//   tick          : one-cycle step strobe from the bpm generator
//   play          : run/stop level
//   mute          : per-voice trigger mask, sampled when a trigger fires
//   edit_we/edit_voice/edit_pattern : pattern write port
//   trig          : registered one-cycle trigger pulse per voice
//   step          : step currently sounding
//   bar_start     : pulse alongside the step-0 triggers
//   running       : high in ARM or RUN
//   patterns      : registered pattern store, voice v at [v*STEPS +: STEPS]
module step_sequencer
  import drum_pkg::*;
#(
  parameter int P_STEPS  = STEPS,
  parameter int P_VOICES = VOICES,
  parameter int P_STEP_W = STEP_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          play,
  input  logic [P_VOICES-1:0]           mute,
  input  logic                          edit_we,
  input  logic [1:0]                    edit_voice,
  input  logic [P_STEPS-1:0]            edit_pattern,
  output logic [P_VOICES-1:0]           trig,
  output logic [P_STEP_W-1:0]           step,
  output logic                          bar_start,
  output logic                          running,
  output logic [P_VOICES*P_STEPS-1:0]   patterns
);

  seq_state_t             state_q, state_d;
  logic [P_STEP_W-1:0]    step_q, step_d;
  logic [P_VOICES-1:0]    trig_q, trig_d;
  logic                   bar_q, bar_d;

  logic [P_VOICES*P_STEPS-1:0] pat_flat;
  logic [P_STEP_W-1:0]         step_inc;
  logic [P_VOICES-1:0]         col_first;
  logic [P_VOICES-1:0]         col_next;

  pattern_regs #(
    .P_STEPS  (P_STEPS),
    .P_VOICES (P_VOICES)
  ) u_pattern_regs (
    .clk      (clk),
    .reset    (reset),
    .we       (edit_we),
    .wvoice   (edit_voice),
    .wdata    (edit_pattern),
    .pat_flat (pat_flat)
  );

  // STEPS is a power of two, so the natural wrap of the counter is the bar wrap.
  assign step_inc = step_q + P_STEP_W'(1);

  // Triggers read the registered store, so an edit landing with a tick only
  // takes effect from the following step.
  for (genvar gi = 0; gi < P_VOICES; gi++) begin : g_col
    assign col_first[gi] = pat_flat[gi*P_STEPS];
    assign col_next[gi]  = pat_flat[gi*P_STEPS + int'(step_inc)];
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      trig_q  <= '0;
      bar_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      trig_q  <= trig_d;
      bar_q   <= bar_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (play) state_d = ARM;
      ARM:     state_d = play ? RUN : IDLE;
      RUN:     if (!play) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Step counter, trigger and bar-start computation
  always_comb begin
    step_d = step_q;
    trig_d = '0;
    bar_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        step_d = '0;
      end
      ARM: begin
        // Ticks in the ARM cycle are dropped; the bar always opens on step 0.
        step_d = '0;
        if (play) begin
          trig_d = col_first & ~mute;
          bar_d  = 1'b1;
        end
      end
      RUN: begin
        if (!play) begin
          step_d = '0;
        end else if (tick) begin
          step_d = step_inc;
          trig_d = col_next & ~mute;
          bar_d  = (step_inc == '0);
        end
      end
      default: begin
        step_d = '0;
      end
    endcase
  end

  assign trig      = trig_q;
  assign step      = step_q;
  assign bar_start = bar_q;
  assign running   = (state_q != IDLE);
  assign patterns  = pat_flat;

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        play = 1'b0;
  logic [3:0]  mute = 4'b0;
  logic        edit_we = 1'b0;
  logic [1:0]  edit_voice = 2'd0;
  logic [7:0]  edit_pattern = 8'h00;
  logic [3:0]  trig;
  logic [2:0]  step;
  logic        bar_start;
  logic        running;
  logic [31:0] patterns;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  step_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .play         (play),
    .mute         (mute),
    .edit_we      (edit_we),
    .edit_voice   (edit_voice),
    .edit_pattern (edit_pattern),
    .trig         (trig),
    .step         (step),
    .bar_start    (bar_start),
    .running      (running),
    .patterns     (patterns)
  );

  typedef struct packed {
    logic [3:0]  trig;
    logic [2:0]  step;
    logic        bar;
    logic        run;
    logic [31:0] pats;
  } exp_t;

  exp_t sb[$];

  // Reference model state: 0 idle, 1 arm, 2 run
  int         m_state = 0;
  logic [2:0] m_step = 3'd0;
  logic [7:0] m_pat [4] = '{default: 8'h00};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] col(input logic [2:0] idx);
    logic [3:0] c;
    for (int v = 0; v < 4; v++) c[v] = m_pat[v][idx];
    return c;
  endfunction

  // Predict the outputs of the coming edge, push them, clock, then pop and compare.
  task automatic cycle();
    exp_t       e;
    int         ns;
    logic [2:0] nstep;
    logic [3:0] ntrig;
    logic       nbar;
    ns = m_state; nstep = m_step; ntrig = 4'b0; nbar = 1'b0;
    case (m_state)
      0: begin
        nstep = 3'd0;
        if (play) ns = 1;
      end
      1: begin
        nstep = 3'd0;
        if (play) begin
          ns = 2; ntrig = col(3'd0) & ~mute; nbar = 1'b1;
        end else begin
          ns = 0;
        end
      end
      default: begin
        if (!play) begin
          ns = 0; nstep = 3'd0;
        end else if (tick) begin
          nstep = m_step + 3'd1;
          ntrig = col(nstep) & ~mute;
          nbar  = (nstep == 3'd0);
        end
      end
    endcase
    if (edit_we) m_pat[edit_voice] = edit_pattern;
    m_state = ns;
    m_step  = nstep;
    e.trig = ntrig;
    e.step = nstep;
    e.bar  = nbar;
    e.run  = (ns != 0);
    e.pats = {m_pat[3], m_pat[2], m_pat[1], m_pat[0]};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    $display("t=%0t tick=%b play=%b trig=%b step=%0d bar=%b run=%b pats=%h",
             $time, tick, play, trig, step, bar_start, running, patterns);
    check_val("trig", 32'(trig), 32'(e.trig));
    check_val("step", 32'(step), 32'(e.step));
    check_val("bar_start", 32'(bar_start), 32'(e.bar));
    check_val("running", 32'(running), 32'(e.run));
    check_val("patterns", patterns, e.pats);
  endtask

  task automatic write_pat(input logic [1:0] v, input logic [7:0] p);
    edit_we = 1'b1; edit_voice = v; edit_pattern = p;
    cycle();
    edit_we = 1'b0;
  endtask

  // One tick cycle followed by a quiet cycle; returns outputs seen after the tick.
  task automatic tick_step(output logic [3:0] t, output logic [2:0] s, output logic b);
    tick = 1'b1;
    cycle();
    t = trig; s = step; b = bar_start;
    tick = 1'b0;
    cycle();
  endtask

  initial begin
    logic [3:0] t;
    logic [2:0] s;
    logic       b;

    // 1: reset and arm with kick = 0001_0001
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_trig", 32'(trig), 32'h0);
    check_val("rst_step", 32'(step), 32'h0);
    check_val("rst_bar", 32'(bar_start), 32'h0);
    check_val("rst_running", 32'(running), 32'h0);
    check_val("rst_patterns", patterns, 32'h0);
    reset = 1'b1;
    cycle();
    write_pat(2'd0, 8'b0001_0001);
    play = 1'b1;
    cycle();
    check_val("arm_running", 32'(running), 32'h1);
    check_val("arm_trig", 32'(trig), 32'h0);
    cycle();
    check_val("bar0_trig", 32'(trig), 32'b0001);
    check_val("bar0_step", 32'(step), 32'h0);
    check_val("bar0_bar", 32'(bar_start), 32'h1);
    cycle();

    // 2: a full bar of ticks; kick on steps 0 and 4 only
    for (int k = 1; k <= 8; k++) begin
      tick_step(t, s, b);
      check_val("bar_step", 32'(s), 32'(k % 8));
      check_val("bar_kick", 32'(t), ((k % 8) == 0 || (k % 8) == 4) ? 32'h1 : 32'h0);
      check_val("bar_start_wrap", 32'(b), ((k % 8) == 0) ? 32'h1 : 32'h0);
    end

    // 3: snare edit landing with the tick into step 2
    tick_step(t, s, b);
    tick = 1'b1; edit_we = 1'b1; edit_voice = 2'd1; edit_pattern = 8'hFF;
    cycle();
    check_val("edit_old_step", 32'(step), 32'h2);
    check_val("edit_old_snare", 32'(trig[1]), 32'h0);
    tick = 1'b0; edit_we = 1'b0;
    cycle();
    tick_step(t, s, b);
    check_val("edit_new_step", 32'(s), 32'h3);
    check_val("edit_new_snare", 32'(t[1]), 32'h1);

    // 4: stop together with a tick at step 5, then replay
    tick_step(t, s, b);
    tick_step(t, s, b);
    check_val("stop_pre_step", 32'(s), 32'h5);
    play = 1'b0; tick = 1'b1;
    cycle();
    check_val("stop_trig", 32'(trig), 32'h0);
    check_val("stop_step", 32'(step), 32'h0);
    check_val("stop_running", 32'(running), 32'h0);
    tick = 1'b0;
    cycle();
    play = 1'b1;
    cycle();
    cycle();
    check_val("replay_step", 32'(step), 32'h0);
    check_val("replay_trig", 32'(trig), 32'b0011);
    cycle();

    // 5: all patterns full, snare muted
    write_pat(2'd0, 8'hFF);
    write_pat(2'd2, 8'hFF);
    write_pat(2'd3, 8'hFF);
    mute = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      tick_step(t, s, b);
      check_val("mute_trig", 32'(t), 32'b1101);
    end
    play = 1'b0;
    cycle();
    tick = 1'b1;
    cycle();
    check_val("idle_tick_trig", 32'(trig), 32'h0);
    tick = 1'b0; play = 1'b1;
    cycle();
    tick = 1'b1;
    cycle();
    check_val("arm_tick_trig", 32'(trig), 32'b1101);
    check_val("arm_tick_step", 32'(step), 32'h0);
    tick = 1'b0;
    cycle();

    // 6: asynchronous reset mid-run at step 6
    mute = 4'b0000;
    for (int k = 0; k < 6; k++) tick_step(t, s, b);
    check_val("pre_rst_step", 32'(s), 32'h6);
    #2 reset = 1'b0;
    #1;
    check_val("async_trig", 32'(trig), 32'h0);
    check_val("async_step", 32'(step), 32'h0);
    check_val("async_bar", 32'(bar_start), 32'h0);
    check_val("async_running", 32'(running), 32'h0);
    check_val("async_patterns", patterns, 32'h0);
    m_state = 0; m_step = 3'd0;
    for (int v = 0; v < 4; v++) m_pat[v] = 8'h00;
    play = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    tick = 1'b1;
    cycle();
    check_val("post_rst_tick_trig", 32'(trig), 32'h0);
    tick = 1'b0;
    cycle();
    play = 1'b1;
    cycle();
    cycle();
    check_val("post_rst_replay_trig", 32'(trig), 32'h0);
    check_val("post_rst_replay_bar", 32'(bar_start), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
